// File: rtl/ccl_issue_unit.sv
// ccl_issue_unit: takes loop-control instructions from fetch, issues them to
// the loop-stack unit for one cycle, waits one cycle, then turns the
// loop-stack response into a fetch redirect or a fault pulse.
module ccl_issue_unit #(
   parameter int STAT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [31:0]       instr_pc,
   input  logic [31:0]       instr_count,
   input  logic [31:0]       instr_target,
   input  logic              flush,
   output logic [1:0]        command,
   output logic [31:0]       address,
   output logic [31:0]       counter,
   output logic [31:0]       inTarget,
   input  logic [31:0]       ccl_target,
   input  logic              ccl_valid,
   input  logic              ccl_full,
   input  logic              ccl_error,
   output logic              redirect,
   output logic [31:0]       redirect_pc,
   output logic              fault,
   output logic [1:0]        fault_code,
   output logic [STAT_W-1:0] issued_count,
   output logic [STAT_W-1:0] fault_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_BREAK = 2'b01;
   localparam logic [1:0] OP_CCL   = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_ILL   = 2'b01;
   localparam logic [1:0] FC_FULL  = 2'b10;
   localparam logic [1:0] FC_LOOP  = 2'b11;

   // Saturating increment: the statistic sticks at all-ones.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      if (v == {STAT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(STAT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [1:0]  op_r;
   logic        accept_s;
   logic        issue_ok_s;
   logic        rsp_redirect_s;
   logic [31:0] rsp_pc_s;
   logic        rsp_fault_s;
   logic [1:0]  rsp_code_s;

   // Handshake and command are gated by reset combinationally so the
   // loop-stack unit never sees a command while reset is held.
   always_comb begin
      instr_ready = (state_r == ST_IDLE) && !reset;
      if (!reset && (state_r == ST_ISSUE)) begin
         command = op_r;
      end else begin
         command = OP_NONE;
      end
   end

   // Accept decode: illegal ops and zero-count loops fault without issuing.
   always_comb begin
      accept_s   = instr_valid && instr_ready && !flush && (instr_op != OP_NONE);
      issue_ok_s = accept_s && (instr_op != OP_ILL) &&
                   !((instr_op == OP_CCL) && (instr_count == 32'd0));
   end

   // Response decode: accept-time faults, or the loop-stack result in WAIT.
   always_comb begin
      rsp_redirect_s = 1'b0;
      rsp_pc_s       = 32'd0;
      rsp_fault_s    = 1'b0;
      rsp_code_s     = FC_NONE;
      if (accept_s && (instr_op == OP_ILL)) begin
         rsp_fault_s = 1'b1;
         rsp_code_s  = FC_ILL;
      end else if (accept_s && (instr_op == OP_CCL) && (instr_count == 32'd0)) begin
         rsp_fault_s = 1'b1;
         rsp_code_s  = FC_LOOP;
      end else if ((state_r == ST_WAIT) && !flush) begin
         case (op_r)
            OP_CCL: begin
               if (ccl_error) begin
                  rsp_fault_s = 1'b1;
                  rsp_code_s  = ccl_full ? FC_FULL : FC_LOOP;
               end else if (ccl_valid) begin
                  rsp_redirect_s = 1'b1;
                  rsp_pc_s       = ccl_target;
               end else begin
                  rsp_redirect_s = 1'b0;
               end
            end
            OP_BREAK: begin
               if (ccl_error) begin
                  rsp_fault_s = 1'b1;
                  rsp_code_s  = FC_LOOP;
               end else begin
                  rsp_redirect_s = 1'b1;
                  rsp_pc_s       = inTarget;
               end
            end
            default: begin
               rsp_redirect_s = 1'b0;
            end
         endcase
      end else begin
         rsp_redirect_s = 1'b0;
      end
   end

   // Next-state: IDLE -> ISSUE -> WAIT -> IDLE, flush aborts to IDLE.
   always_comb begin
      case (state_r)
         ST_IDLE:  state_nxt_s = issue_ok_s ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_nxt_s = flush ? ST_IDLE : ST_WAIT;
         ST_WAIT:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State, operand latches, response pulses and statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         op_r         <= OP_NONE;
         address      <= 32'd0;
         counter      <= 32'd0;
         inTarget     <= 32'd0;
         redirect     <= 1'b0;
         redirect_pc  <= 32'd0;
         fault        <= 1'b0;
         fault_code   <= FC_NONE;
         issued_count <= {STAT_W{1'b0}};
         fault_count  <= {STAT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (issue_ok_s) begin
            op_r     <= instr_op;
            address  <= instr_pc;
            counter  <= instr_count;
            inTarget <= instr_target;
         end
         redirect   <= rsp_redirect_s;
         fault      <= rsp_fault_s;
         fault_code <= rsp_fault_s ? rsp_code_s : FC_NONE;
         if (rsp_redirect_s) begin
            redirect_pc <= rsp_pc_s;
         end
         if (state_r == ST_ISSUE) begin
            issued_count <= sat_inc(issued_count);
         end
         if (rsp_fault_s) begin
            fault_count <= sat_inc(fault_count);
         end
      end
   end

endmodule

// File: tb/tb_ccl_issue_unit.sv
// Directed bench for ccl_issue_unit with a transaction-level reference model.
module tb_ccl_issue_unit;

   localparam int SW  = 3;
   localparam int SAT = (1 << SW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic          instr_ready;
   logic [1:0]    instr_op;
   logic [31:0]   instr_pc, instr_count, instr_target;
   logic          flush;
   logic [1:0]    command;
   logic [31:0]   address, counter, inTarget;
   logic [31:0]   ccl_target;
   logic          ccl_valid, ccl_full, ccl_error;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          fault;
   logic [1:0]    fault_code;
   logic [SW-1:0] issued_count, fault_count;

   ccl_issue_unit #(.STAT_W(SW)) dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_pc(instr_pc), .instr_count(instr_count), .instr_target(instr_target),
      .flush(flush), .command(command),
      .address(address), .counter(counter), .inTarget(inTarget),
      .ccl_target(ccl_target), .ccl_valid(ccl_valid), .ccl_full(ccl_full),
      .ccl_error(ccl_error), .redirect(redirect), .redirect_pc(redirect_pc),
      .fault(fault), .fault_code(fault_code),
      .issued_count(issued_count), .fault_count(fault_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference model: one in-flight transaction, tracked by edges since accept.
   bit          m_busy;
   int          m_age;
   logic [1:0]  m_op;
   logic [31:0] m_addr, m_cnt, m_tgt, m_rpc;
   bit          m_redirect, m_fault;
   logic [1:0]  m_code;
   int          m_issued, m_faults;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic model_clear();
      m_busy = 0; m_age = 0; m_op = 2'b00;
      m_addr = 32'd0; m_cnt = 32'd0; m_tgt = 32'd0; m_rpc = 32'd0;
      m_redirect = 0; m_fault = 0; m_code = 2'b00;
      m_issued = 0; m_faults = 0;
   endtask

   task automatic model_fault(input logic [1:0] code);
      m_fault = 1; m_code = code;
   endtask

   // Advance the model by one clock edge using the inputs applied at that edge.
   task automatic model_step();
      if (reset) begin
         model_clear();
      end else begin
         m_redirect = 0; m_fault = 0; m_code = 2'b00;
         if (m_busy && m_age == 0) begin
            m_issued = sat(m_issued);
            if (flush) m_busy = 0;
            else m_age = 1;
         end else if (m_busy) begin
            m_busy = 0;
            if (!flush) begin
               if (ccl_error) model_fault((m_op == 2'b10 && ccl_full) ? 2'b10 : 2'b11);
               else if (m_op == 2'b01) begin m_redirect = 1; m_rpc = m_tgt; end
               else if (ccl_valid) begin m_redirect = 1; m_rpc = ccl_target; end
            end
         end else if (instr_valid && !flush && instr_op != 2'b00) begin
            if (instr_op == 2'b11) model_fault(2'b01);
            else if (instr_op == 2'b10 && instr_count == 32'd0) model_fault(2'b11);
            else begin
               m_busy = 1; m_age = 0; m_op = instr_op;
               m_addr = instr_pc; m_cnt = instr_count; m_tgt = instr_target;
            end
         end
         if (m_fault) m_faults = sat(m_faults);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("instr_ready", {31'd0, instr_ready}, {31'd0, !reset && !m_busy});
         chk("command", {30'd0, command},
             (reset || !(m_busy && m_age == 0)) ? 32'd0 : {30'd0, m_op});
         chk("address", address, m_addr);
         chk("counter", counter, m_cnt);
         chk("inTarget", inTarget, m_tgt);
         chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
         chk("redirect_pc", redirect_pc, m_rpc);
         chk("fault", {31'd0, fault}, {31'd0, m_fault});
         chk("fault_code", {30'd0, fault_code}, {30'd0, m_code});
         chk("issued_count", {29'd0, issued_count}, m_issued);
         chk("fault_count", {29'd0, fault_count}, m_faults);
         chk("no_both_pulses", {31'd0, redirect && fault}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clock);
      model_step();
      #2;
   endtask

   task automatic clear_in();
      instr_valid = 1'b0; instr_op = 2'b00;
      instr_pc = 32'd0; instr_count = 32'd0; instr_target = 32'd0;
      flush = 1'b0; ccl_target = 32'd0;
      ccl_valid = 1'b0; ccl_full = 1'b0; ccl_error = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Present one instruction for a single edge.
   task automatic send(input logic [1:0] op, input logic [31:0] pc,
                       input logic [31:0] cnt, input logic [31:0] tgt);
      instr_valid = 1'b1; instr_op = op;
      instr_pc = pc; instr_count = cnt; instr_target = tgt;
      tick();
      instr_valid = 1'b0; instr_op = 2'b00;
   endtask

   // Apply loop-stack status during WAIT and take the response edge.
   task automatic respond(input bit v, input bit f, input bit e, input logic [31:0] t);
      ccl_valid = v; ccl_full = f; ccl_error = e; ccl_target = t;
      tick();
      ccl_valid = 1'b0; ccl_full = 1'b0; ccl_error = 1'b0; ccl_target = 32'd0;
   endtask

   initial begin
      model_clear();
      clear_in();
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      chk("reset_ready", {31'd0, instr_ready}, 32'd0);
      chk("reset_cmd", {30'd0, command}, 32'd0);
      reset = 1'b0;
      tick();

      // ccl taken: redirect to body start two edges after accept
      send(2'b10, 32'h100, 32'd3, 32'h80);
      chk("lit_ccl_cmd", {30'd0, command}, 32'd2);
      chk("lit_ccl_addr", address, 32'h100);
      ccl_valid = 1'b1;            // ignored: unit is in ISSUE
      tick();
      ccl_valid = 1'b0;
      chk("lit_ccl_cmd_gone", {30'd0, command}, 32'd0);
      respond(1'b1, 1'b0, 1'b0, 32'h80);
      chk("lit_ccl_redirect", {31'd0, redirect}, 32'd1);
      chk("lit_ccl_rpc", redirect_pc, 32'h80);
      chk("lit_ccl_ready", {31'd0, instr_ready}, 32'd1);
      chk("lit_ccl_issued", {29'd0, issued_count}, 32'd1);
      tick();

      // illegal op then zero-count ccl: two faults, nothing issued
      do_reset();
      send(2'b11, 32'h10, 32'd5, 32'h20);
      chk("lit_ill_fault", {31'd0, fault}, 32'd1);
      chk("lit_ill_code", {30'd0, fault_code}, 32'd1);
      send(2'b10, 32'h10, 32'd0, 32'h20);
      chk("lit_zero_code", {30'd0, fault_code}, 32'd3);
      tick();
      chk("lit_two_faults", {29'd0, fault_count}, 32'd2);
      chk("lit_none_issued", {29'd0, issued_count}, 32'd0);

      // ccl with overflow (error+full+valid): overflow fault, no redirect
      send(2'b10, 32'h140, 32'd7, 32'h120);
      tick();
      respond(1'b1, 1'b1, 1'b1, 32'h120);
      chk("lit_ovf_code", {30'd0, fault_code}, 32'd2);
      chk("lit_ovf_noredir", {31'd0, redirect}, 32'd0);
      // ccl with error only, then all-zero fall-through
      send(2'b10, 32'h150, 32'd2, 32'h130);
      tick();
      respond(1'b0, 1'b0, 1'b1, 32'h0);
      send(2'b10, 32'h160, 32'd2, 32'h130);
      tick();
      respond(1'b0, 1'b0, 1'b0, 32'h0);

      // break: redirect to latched exit, then break with error
      send(2'b01, 32'h1f0, 32'd0, 32'h200);
      ccl_error = 1'b1;            // ignored: unit is in ISSUE
      tick();
      ccl_error = 1'b0;
      respond(1'b0, 1'b0, 1'b0, 32'h0);
      chk("lit_brk_rpc", redirect_pc, 32'h200);
      send(2'b01, 32'h2f0, 32'd0, 32'h300);
      tick();
      respond(1'b1, 1'b0, 1'b1, 32'h44);

      // flush during WAIT discards a taken ccl
      send(2'b10, 32'h400, 32'd4, 32'h380);
      tick();
      flush = 1'b1;
      respond(1'b1, 1'b0, 1'b0, 32'h380);
      flush = 1'b0;
      chk("lit_flush_noredir", {31'd0, redirect}, 32'd0);
      chk("lit_flush_ready", {31'd0, instr_ready}, 32'd1);
      // flush during ISSUE, then flush in IDLE blocks acceptance
      send(2'b01, 32'h500, 32'd0, 32'h480);
      flush = 1'b1;
      tick();
      send(2'b01, 32'h600, 32'd0, 32'h580);
      flush = 1'b0;
      chk("lit_idle_flush_cmd", {30'd0, command}, 32'd0);
      tick();

      // reset during ISSUE clears command immediately
      send(2'b10, 32'h700, 32'd9, 32'h680);
      reset = 1'b1;
      #1;
      chk("lit_rst_cmd_comb", {30'd0, command}, 32'd0);
      tick();
      reset = 1'b0;
      chk("lit_rst_addr", address, 32'd0);
      chk("lit_rst_issued", {29'd0, issued_count}, 32'd0);
      tick();

      // back-to-back breaks and illegal ops saturate both counters
      instr_valid = 1'b1; instr_op = 2'b01; instr_target = 32'h900;
      repeat (27) tick();
      chk("lit_issued_sat", {29'd0, issued_count}, SAT);
      instr_op = 2'b11;
      repeat (9) tick();
      instr_valid = 1'b0; instr_op = 2'b00;
      tick();
      chk("lit_faults_sat", {29'd0, fault_count}, SAT);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
